binarize_adaptive: RTL and testbench
====================================

// Module: binarize_adaptive
// PURPOSE
//  Streaming pixel binarizer for the camera pipeline; successor to the fixed-threshold binarizer.
//  Parametrised pixel width; runtime mode select: fixed threshold, line hysteresis, or
//  running-mean adaptive threshold. Settings are latched per frame. Counts foreground pixels per frame.
//  Sits between the grey/Bayer-to-grey stage and the display/VGA writer.
// PARAMETERS
//  DW         10  pixel width (data and thresholds)
//  AVG_SHIFT  4   running-mean time constant; weight of new pixel = 2^-AVG_SHIFT
//  CNT_W      22  width of per-frame ones counter (saturating)
// PORTS
//  CLOCK        in   1         pipeline clock
//  RESET        in   1         synchronous, active-high reset
//  iDval        in   1         input pixel valid
//  iSOF         in   1         first pixel of frame; meaningful only with iDval
//  iSOL         in   1         first pixel of line; meaningful only with iDval (SOF implies SOL)
//  iData        in   DW        grey pixel
//  iMode        in   2         0 fixed, 1 hysteresis, 2 adaptive, 3 = treated as 0
//  iThreshLo    in   DW        low threshold (hysteresis)
//  iThreshHi    in   DW        threshold (mode 0) / high threshold (mode 1)
//  iOffset      in   DW+1      signed offset added to the running mean (mode 2)
//  iInvert      in   1         invert the binary decision
//  oDval        out  1         output valid
//  oSOF         out  1         iSOF delayed, qualified by oDval
//  oSOL         out  1         iSOL delayed, qualified by oDval
//  oData        out  DW        all-ones for foreground, 0 otherwise
//  oOnesCount   out  CNT_W     foreground count of previous complete frame
//  oCountValid  out  1         1-cycle pulse when oOnesCount updates
// BEHAVIOUR
//  Reset (RESET=1 at a CLOCK edge): all outputs 0; pipeline, counters, and flags cleared.
//   Shadow settings: mode 0, Lo=Hi=2^DW-1, offset 0, invert 0.
//  Latency: fixed 2 cycles; oDval/oSOF/oSOL/oData are iDval/iSOF/iSOL/result delayed 2 cycles.
//   No stall; stage 1 registers input and settings, stage 2 registers decision.
//  oData = 0 whenever oDval = 0. Internal state (hyst, mean, count) updates only on valid pixels.
//  Settings shadow: on a cycle with iDval&iSOF, iMode/iThresh*/iOffset/iInvert are captured.
//   They apply to that pixel and the rest of the frame; changes mid-frame are ignored.
//  Mode 0: fg = (pix > Hi).
//  Mode 1: if pix > Hi then fg=1; else if pix < Lo then fg=0; else fg = prev fg on the same line.
//   prev fg is forced to 0 at each SOL pixel before evaluation. Hi is checked first, so Lo>Hi is legal.
//  Mode 2: acc holds DW+AVG_SHIFT bits; mean = acc >> AVG_SHIFT.
//   On an SOL pixel, acc <= pix << AVG_SHIFT, and the threshold uses mean = pix.
//   Otherwise the threshold uses the mean before update, then acc <= acc + pix - (acc >> AVG_SHIFT).
//   thr = clamp(mean + iOffset, 0, 2^DW-1), computed in DW+2 bit signed arithmetic. fg = (pix > thr).
//  Output: oData = {DW{fg ^ invert}}.
//  Counter: counts valid output pixels with oData != 0; saturates at 2^CNT_W-1.
//   On an output pixel with oDval&oSOF: if a previous SOF was seen since reset,
//   oOnesCount <= count and oCountValid pulses. count restarts with the current pixel's contribution.
//   First frame after reset: no pulse.
//  Simultaneous SOF+SOL: treat as SOF plus SOL (both latch settings and line reset).
//  Reset mid-frame: partial count discarded, no oCountValid; the next SOF is treated as first.
// TESTING
//  Mode 0, Hi=512, pixels 511,512,513 -> oData 0,0,1023, each 2 cycles after input; oDval follows.
//  Mode 1, Lo=300, Hi=700, line 800,500,200,500 -> 1023,1023,0,0; new SOL with 500 -> 0.
//  Mode 2, AVG_SHIFT=4, offset +10: line of 100s then 115 -> 1023; 105 -> 0.
//   offset -1023 -> thr clamps to 0.
//  Change iThreshHi mid-frame 512->100, pixel 300 -> still 0 until the next SOF pixel, then 1023.
//  Two frames of 16 pixels, 5 foreground in frame 1 -> no pulse at the 1st oSOF;
//   at the 2nd oSOF, oCountValid=1 and oOnesCount=5. iInvert=1 gives 11.
//  RESET mid-frame and iDval gaps -> outputs 0 the next cycle, no count pulse at the next SOF,
//   and mean/hyst state frozen across gaps.

Source files
------------

// File: rtl/binarize_adaptive.sv
// Streaming pixel binarizer: fixed, line-hysteresis or running-mean adaptive threshold,
// with per-frame latched settings and a saturating per-frame foreground counter.
module binarize_adaptive #(
    parameter int DW        = 10,
    parameter int AVG_SHIFT = 4,
    parameter int CNT_W     = 22
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             iDval,
    input  logic             iSOF,
    input  logic             iSOL,
    input  logic [DW-1:0]    iData,
    input  logic [1:0]       iMode,
    input  logic [DW-1:0]    iThreshLo,
    input  logic [DW-1:0]    iThreshHi,
    input  logic [DW:0]      iOffset,
    input  logic             iInvert,
    output logic             oDval,
    output logic             oSOF,
    output logic             oSOL,
    output logic [DW-1:0]    oData,
    output logic [CNT_W-1:0] oOnesCount,
    output logic             oCountValid
);
    localparam int AW = DW + AVG_SHIFT;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'd0,
        MODE_HYST  = 2'd1,
        MODE_ADAPT = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    // Stage 1: pixel and frame-latched settings
    logic          r_dval1, r_sof1, r_sol1;
    logic [DW-1:0] r_pix1;
    mode_e         r_mode;
    logic [DW-1:0] r_lo, r_hi;
    logic [DW:0]   r_off;
    logic          r_inv;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_dval1 <= 1'b0;
            r_sof1  <= 1'b0;
            r_sol1  <= 1'b0;
            r_pix1  <= '0;
            r_mode  <= MODE_FIXED;
            r_lo    <= '1;
            r_hi    <= '1;
            r_off   <= '0;
            r_inv   <= 1'b0;
        end else begin
            r_dval1 <= iDval;
            r_sof1  <= iDval & iSOF;
            r_sol1  <= iDval & (iSOL | iSOF);
            r_pix1  <= iData;
            if (iDval && iSOF) begin
                r_mode <= mode_e'(iMode);
                r_lo   <= iThreshLo;
                r_hi   <= iThreshHi;
                r_off  <= iOffset;
                r_inv  <= iInvert;
            end
        end
    end

    // Decision state
    logic             r_hyst;
    logic [AW-1:0]    r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_seen;

    logic             w_prev, w_fg_hyst, w_fg, w_on;
    logic [DW-1:0]    w_mean, w_thr;
    logic [AW:0]      w_sum;
    logic [AW-1:0]    w_acc_nxt;
    logic signed [DW+1:0] w_thr_s;

    always_comb begin
        w_prev    = r_sol1 ? 1'b0 : r_hyst;
        w_fg_hyst = w_prev;
        if (r_pix1 > r_hi)
            w_fg_hyst = 1'b1;
        else if (r_pix1 < r_lo)
            w_fg_hyst = 1'b0;

        w_mean    = r_sol1 ? r_pix1 : DW'(r_acc >> AVG_SHIFT);
        w_sum     = {1'b0, r_acc} + (AW+1)'(r_pix1) - (AW+1)'(r_acc >> AVG_SHIFT);
        w_acc_nxt = r_sol1 ? (AW'(r_pix1) << AVG_SHIFT) : w_sum[AW-1:0];

        // Sign bit catches the negative clamp; bit DW catches overflow above full scale
        w_thr_s = $signed({2'b00, w_mean}) + $signed({r_off[DW], r_off});
        if (w_thr_s[DW+1])
            w_thr = '0;
        else if (w_thr_s[DW])
            w_thr = '1;
        else
            w_thr = w_thr_s[DW-1:0];

        case (r_mode)
            MODE_HYST:  w_fg = w_fg_hyst;
            MODE_ADAPT: w_fg = (r_pix1 > w_thr);
            default:    w_fg = (r_pix1 > r_hi);
        endcase
        w_on = w_fg ^ r_inv;
    end

    // Stage 2: output register, state update and frame counter
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            oDval       <= 1'b0;
            oSOF        <= 1'b0;
            oSOL        <= 1'b0;
            oData       <= '0;
            oOnesCount  <= '0;
            oCountValid <= 1'b0;
            r_hyst      <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_seen      <= 1'b0;
        end else begin
            oDval       <= r_dval1;
            oSOF        <= r_sof1;
            oSOL        <= r_sol1;
            oData       <= {DW{r_dval1 & w_on}};
            oCountValid <= 1'b0;
            if (r_dval1) begin
                r_hyst <= w_fg_hyst;
                r_acc  <= w_acc_nxt;
                if (r_sof1) begin
                    r_cnt  <= CNT_W'(w_on);
                    r_seen <= 1'b1;
                    if (r_seen) begin
                        oOnesCount  <= r_cnt;
                        oCountValid <= 1'b1;
                    end
                end else if (w_on && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_binarize_adaptive.sv
// Directed bench for binarize_adaptive: vector table for the pixel path, hand sequences
// for frame counting and mid-frame reset.
module tb_binarize_adaptive;
    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        iDval, iSOF, iSOL, iInvert;
    logic [9:0]  iData, iThreshLo, iThreshHi;
    logic [1:0]  iMode;
    logic [10:0] iOffset;
    logic        oDval, oSOF, oSOL, oCountValid;
    logic [9:0]  oData;
    logic [21:0] oOnesCount;

    binarize_adaptive #(.DW(10), .AVG_SHIFT(4), .CNT_W(22)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .iDval(iDval), .iSOF(iSOF), .iSOL(iSOL),
        .iData(iData), .iMode(iMode), .iThreshLo(iThreshLo), .iThreshHi(iThreshHi),
        .iOffset(iOffset), .iInvert(iInvert), .oDval(oDval), .oSOF(oSOF), .oSOL(oSOL),
        .oData(oData), .oOnesCount(oOnesCount), .oCountValid(oCountValid)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic        dval, sof, sol;
        logic [9:0]  pix;
        logic [1:0]  mode;
        logic [9:0]  lo, hi;
        logic [10:0] off;
        logic        inv;
        logic [9:0]  exp;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    int          pulses = 0;
    logic [21:0] last_cnt = '0;
    logic        last_sof = 1'b0;

    always @(negedge CLOCK) begin
        if (oCountValid) begin
            pulses   = pulses + 1;
            last_cnt = oOnesCount;
            last_sof = oSOF;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic dv, input logic sf, input logic sl, input int pix,
                       input int mode, input int lo, input int hi, input int off,
                       input logic inv, input int exp);
        vecs[nv].dval = dv;
        vecs[nv].sof  = sf;
        vecs[nv].sol  = sl;
        vecs[nv].pix  = 10'(pix);
        vecs[nv].mode = 2'(mode);
        vecs[nv].lo   = 10'(lo);
        vecs[nv].hi   = 10'(hi);
        vecs[nv].off  = 11'(off);
        vecs[nv].inv  = inv;
        vecs[nv].exp  = 10'(exp);
        nv++;
    endtask

    task automatic drive(input vec_t v);
        iDval = v.dval; iSOF = v.sof; iSOL = v.sol; iData = v.pix; iMode = v.mode;
        iThreshLo = v.lo; iThreshHi = v.hi; iOffset = v.off; iInvert = v.inv;
    endtask

    task automatic idle();
        iDval = 1'b0; iSOF = 1'b0; iSOL = 1'b0; iData = '0;
        @(posedge CLOCK); #1;
    endtask

    task automatic send_px(input logic sf, input int pix, input logic inv);
        iDval = 1'b1; iSOF = sf; iSOL = sf; iData = 10'(pix); iMode = 2'd0;
        iThreshLo = '0; iThreshHi = 10'd512; iOffset = '0; iInvert = inv;
        @(posedge CLOCK); #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLOCK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic count_run(input logic inv, input int exp_cnt);
        int base;
        do_reset();
        base = pulses;
        for (int k = 0; k < 16; k++)
            send_px(k == 0, ((k % 3 == 0) && (k < 15)) ? 600 : 100, inv);
        send_px(1'b1, 100, inv);
        repeat (3) idle();
        check("count_pulses", pulses - base, 1);
        check("count_value", 32'(last_cnt), exp_cnt);
        check("count_with_sof", 32'(last_sof), 1);
    endtask

    initial begin
        vec_t v;
        int   base;
        RESET = 1'b1;
        iDval = 1'b1; iSOF = 1'b1; iSOL = 1'b1; iData = 10'd1000; iMode = 2'd0;
        iThreshLo = '0; iThreshHi = '0; iOffset = '0; iInvert = 1'b1;

        // Reset state
        repeat (3) @(posedge CLOCK);
        #1;
        check("rst_oDval", 32'(oDval), 0);
        check("rst_oSOF", 32'(oSOF), 0);
        check("rst_oSOL", 32'(oSOL), 0);
        check("rst_oData", 32'(oData), 0);
        check("rst_oOnesCount", 32'(oOnesCount), 0);
        check("rst_oCountValid", 32'(oCountValid), 0);
        RESET = 1'b0;
        iDval = 1'b0;

        // Mode 0 fixed
        add(1, 1, 1, 511, 0, 0, 512, 0, 0, 0);
        add(1, 0, 0, 512, 0, 0, 512, 0, 0, 0);
        add(1, 0, 0, 513, 0, 0, 512, 0, 0, 1023);
        add(0, 0, 0, 900, 0, 0, 512, 0, 0, 0);
        // Mode 1 hysteresis
        add(1, 1, 1, 800, 1, 300, 700, 0, 0, 1023);
        add(1, 0, 0, 500, 1, 300, 700, 0, 0, 1023);
        add(1, 0, 0, 200, 1, 300, 700, 0, 0, 0);
        add(1, 0, 0, 500, 1, 300, 700, 0, 0, 0);
        add(1, 0, 1, 500, 1, 300, 700, 0, 0, 0);
        add(1, 0, 0, 800, 1, 300, 700, 0, 0, 1023);
        add(0, 0, 0, 0, 1, 300, 700, 0, 0, 0);
        add(1, 0, 0, 500, 1, 300, 700, 0, 0, 1023);
        // Mode 1 with Lo > Hi
        add(1, 1, 1, 500, 1, 700, 300, 0, 0, 1023);
        add(1, 0, 0, 200, 1, 700, 300, 0, 0, 0);
        // Mode 2 adaptive, offset +10
        add(1, 1, 1, 100, 2, 0, 0, 10, 0, 0);
        add(1, 0, 0, 100, 2, 0, 0, 10, 0, 0);
        add(1, 0, 0, 100, 2, 0, 0, 10, 0, 0);
        add(1, 0, 0, 115, 2, 0, 0, 10, 0, 1023);
        add(1, 0, 0, 105, 2, 0, 0, 10, 0, 0);
        add(0, 0, 0, 0, 2, 0, 0, 10, 0, 0);
        add(1, 0, 0, 115, 2, 0, 0, 10, 0, 1023);
        // Mode 2, offset -1023 clamps low, +1023 clamps high
        add(1, 1, 1, 0, 2, 0, 0, 11'h401, 0, 0);
        add(1, 0, 0, 1, 2, 0, 0, 11'h401, 0, 1023);
        add(1, 1, 1, 1023, 2, 0, 0, 11'h3FF, 0, 0);
        // Mid-frame threshold change ignored until next SOF
        add(1, 1, 1, 300, 0, 0, 512, 0, 0, 0);
        add(1, 0, 0, 300, 0, 0, 100, 0, 0, 0);
        add(1, 1, 1, 300, 0, 0, 100, 0, 0, 1023);
        // Mode 3 behaves as fixed
        add(1, 1, 1, 600, 3, 0, 512, 0, 0, 1023);
        add(1, 0, 0, 400, 3, 0, 512, 0, 0, 0);
        // Invert
        add(1, 1, 1, 600, 0, 0, 512, 0, 1, 0);
        add(1, 0, 0, 10, 0, 0, 512, 0, 1, 1023);

        for (int i = 0; i <= nv; i++) begin
            if (i < nv) drive(vecs[i]);
            else iDval = 1'b0;
            @(posedge CLOCK); #1;
            if (i >= 1) begin
                v = vecs[i-1];
                check($sformatf("v%0d_oDval", i-1), 32'(oDval), 32'(v.dval));
                check($sformatf("v%0d_oSOF", i-1), 32'(oSOF), 32'(v.dval & v.sof));
                check($sformatf("v%0d_oSOL", i-1), 32'(oSOL), 32'(v.dval & (v.sol | v.sof)));
                check($sformatf("v%0d_oData", i-1), 32'(oData), 32'(v.exp));
            end
        end
        idle();

        // Frame counter, normal and inverted
        count_run(1'b0, 5);
        count_run(1'b1, 11);

        // Reset mid-frame
        do_reset();
        send_px(1'b1, 600, 1'b0);
        send_px(1'b0, 600, 1'b0);
        RESET = 1'b1;
        iDval = 1'b1; iData = 10'd600;
        @(posedge CLOCK); #1;
        check("midrst_oDval", 32'(oDval), 0);
        check("midrst_oData", 32'(oData), 0);
        check("midrst_oCountValid", 32'(oCountValid), 0);
        RESET = 1'b0;
        base = pulses;
        send_px(1'b1, 600, 1'b0);
        send_px(1'b0, 600, 1'b0);
        send_px(1'b0, 100, 1'b0);
        send_px(1'b0, 100, 1'b0);
        send_px(1'b1, 100, 1'b0);
        repeat (3) idle();
        check("midrst_pulses", pulses - base, 1);
        check("midrst_count", 32'(last_cnt), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
